scan_data_distributor: RTL and testbench

SCAN_DATA_DISTRIBUTOR -- requirements
Module: scan_data_distributor

---
 rtl/scan_data_distributor.sv | 160 ++++++++++++++++
 tb/tb_scan_data_distributor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_data_distributor.sv
// -----------------------------------------------------------------------------
// scan_data_distributor
//
// Distributes a serial bit stream onto an 8-bit registered output, either one
// bit at a time (addressed write) or as a complete 8-bit scan frame that is
// assembled in a shadow register and copied to dout only once it is complete.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   mode       in   1  0 = addressed write, 1 = scan frame (sampled in IDLE)
//   addr       in   3  target bit (addressed) or start bit (scan)
//   din        in   1  serial data bit
//   in_valid   in   1  din/addr/mode valid
//   in_ready   out  1  block can accept input
//   dout       out  8  registered distributed data
//   out_valid  out  1  completed scan frame present on dout (HOLD state)
//   out_ready  in   1  consumer accepts frame
//
// Configuration macro:
//   FRAME_TIMEOUT_EN  when defined, a partially received frame is abandoned
//                     after 16 consecutive COLLECT cycles without a transfer.
// -----------------------------------------------------------------------------
module scan_data_distributor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic [2:0] addr,
  input  logic       din,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] dout,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] shadow_q, shadow_d;
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
`ifdef FRAME_TIMEOUT_EN
  logic [3:0] timer_q, timer_d;
`endif

  logic       xfer_s;
  logic [7:0] frame_s;

  // in_ready is gated by rst_n so it drops immediately on reset assertion.
  assign in_ready  = rst_n & (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign dout      = dout_q;
  assign xfer_s    = in_valid & in_ready;

  // Next-state and datapath computation for the IDLE/COLLECT/HOLD machine.
  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    shadow_d = shadow_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    frame_s  = shadow_q;
`ifdef FRAME_TIMEOUT_EN
    timer_d  = timer_q;
`endif
    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          if (mode == 1'b0) begin
            dout_d[addr] = din;
          end else begin
            shadow_d[addr] = din;
            ptr_d          = addr + 3'd1;
            cnt_d          = 4'd1;
            state_d        = COLLECT;
`ifdef FRAME_TIMEOUT_EN
            timer_d        = 4'd0;
`endif
          end
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (xfer_s) begin
          // frame_s includes the bit arriving this edge, so the completing
          // transfer copies all eight bits to dout at once.
          frame_s[ptr_q] = din;
          shadow_d       = frame_s;
          ptr_d          = ptr_q + 3'd1;
          cnt_d          = cnt_q + 4'd1;
`ifdef FRAME_TIMEOUT_EN
          timer_d        = 4'd0;
`endif
          if (cnt_q == 4'd7) begin
            dout_d  = frame_s;
            state_d = HOLD;
          end else begin
            state_d = COLLECT;
          end
        end else begin
`ifdef FRAME_TIMEOUT_EN
          // Timer holds 15 on the 16th idle cycle: abandon the frame.
          if (timer_q == 4'd15) begin
            state_d  = IDLE;
            shadow_d = 8'h00;
            ptr_d    = 3'd0;
            cnt_d    = 4'd0;
            timer_d  = 4'd0;
          end else begin
            timer_d  = timer_q + 4'd1;
          end
`else
          state_d = COLLECT;
`endif
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dout_q   <= 8'h00;
      shadow_q <= 8'h00;
      ptr_q    <= 3'd0;
      cnt_q    <= 4'd0;
`ifdef FRAME_TIMEOUT_EN
      timer_q  <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      shadow_q <= shadow_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
`ifdef FRAME_TIMEOUT_EN
      timer_q  <= timer_d;
`endif
    end
  end

endmodule

// File: tb/tb_scan_data_distributor.sv
// -----------------------------------------------------------------------------
// tb_scan_data_distributor
//
// Directed self-checking bench for scan_data_distributor. Expected dout values
// are pushed to a scoreboard queue when the stimulus is driven and popped when
// the DUT presents the result. Define FRAME_TIMEOUT_EN to exercise the frame
// timeout; otherwise the indefinite-wait behaviour is exercised.
// -----------------------------------------------------------------------------
module tb_scan_data_distributor;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic [2:0] addr;
  logic       din;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dout;
  logic       out_valid;
  logic       out_ready;

  int         checks;
  int         errors;
  logic [7:0] exp_q[$];
  logic [7:0] model_dout;
  logic [7:0] exp_v;

  scan_data_distributor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .addr      (addr),
    .din       (din),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic cyc(input logic v, input logic m, input logic [2:0] a,
                     input logic d, input logic ordy);
    in_valid  = v;
    mode      = m;
    addr      = a;
    din       = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_dout"}, dout, model_dout);
    chk({tag, "_ovalid"}, {7'd0, out_valid}, 8'd0);
    chk({tag, "_iready"}, {7'd0, in_ready}, 8'd1);
  endtask

  // Addressed write: dout[a] = d on the next edge.
  task automatic addr_write(input logic [2:0] a, input logic d, input logic [7:0] exp);
    exp_q.push_back(exp);
    cyc(1'b1, 1'b0, a, d, 1'b0);
    exp_v = exp_q.pop_front();
    chk("awr_dout", dout, exp_v);
    chk("awr_ovalid", {7'd0, out_valid}, 8'd0);
    model_dout = exp_v;
  endtask

  // Scan frame: bits[i] is the i-th bit sent. After the first bit mode/addr
  // are driven with misleading values, which the DUT must ignore. An optional
  // gap of in_valid=0 cycles follows the third bit.
  task automatic send_frame(input logic [2:0] a, input logic [7:0] bits,
                            input logic [7:0] exp, input logic ordy, input int gap);
    exp_q.push_back(exp);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) cyc(1'b1, 1'b1, a, bits[i], ordy);
      else        cyc(1'b1, 1'b0, a ^ 3'd5, bits[i], ordy);
      if (i < 7) begin
        idle_check("collect");
        if (i == 2) begin
          for (int g = 0; g < gap; g++) begin
            cyc(1'b0, 1'b0, 3'd0, 1'b1, ordy);
            idle_check("gap");
          end
        end
      end else begin
        chk("frame_ovalid", {7'd0, out_valid}, 8'd1);
        chk("frame_iready", {7'd0, in_ready}, 8'd0);
        exp_v = exp_q.pop_front();
        chk("frame_dout", dout, exp_v);
        model_dout = exp_v;
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    model_dout = 8'h00;
    rst_n      = 1'b0;
    mode       = 1'b0;
    addr       = 3'd0;
    din        = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;

    // Reset state.
    #3;
    chk("rst_dout", dout, 8'h00);
    chk("rst_ovalid", {7'd0, out_valid}, 8'd0);
    chk("rst_iready", {7'd0, in_ready}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Addressed writes, first one on the first edge after reset release.
    addr_write(3'd3, 1'b1, 8'h08);
    addr_write(3'd7, 1'b1, 8'h88);

    // Frame from addr 0: 1,0,1,0,0,1,0,1 -> A5.
    send_frame(3'd0, 8'b1010_0101, 8'hA5, 1'b0, 0);

    // HOLD for 5 cycles with in_valid=1 offering a write that would flip bit 0.
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      chk("hold_dout", dout, 8'hA5);
      chk("hold_ovalid", {7'd0, out_valid}, 8'd1);
      chk("hold_iready", {7'd0, in_ready}, 8'd0);
    end
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    idle_check("release");

    // Back-to-back wrapping frame from addr 6 with out_ready held high
    // throughout COLLECT: 1,1,0,0,0,0,0,0 -> C0.
    send_frame(3'd6, 8'b0000_0011, 8'hC0, 1'b1, 0);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    idle_check("release2");

    // Reset after 4 scan bits discards the partial frame.
    cyc(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", dout, 8'h00);
    chk("midrst_ovalid", {7'd0, out_valid}, 8'd0);
    chk("midrst_iready", {7'd0, in_ready}, 8'd0);
    model_dout = 8'h00;
    in_valid   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Frame from addr 2: 0,0,0,0,1,1,1,1 -> bits 6,7,0,1 set -> C3.
    send_frame(3'd2, 8'b1111_0000, 8'hC3, 1'b0, 0);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    idle_check("release3");
    addr_write(3'd2, 1'b1, 8'hC7);

`ifdef FRAME_TIMEOUT_EN
    // Three scan bits, then 16 idle cycles abandon the frame.
    cyc(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      idle_check("tmo_wait");
    end
    // Back in IDLE: an addressed write lands on dout immediately.
    addr_write(3'd3, 1'b1, 8'hCF);
    // A following frame from addr 0: 0,0,0,0,0,0,0,1 -> 80.
    send_frame(3'd0, 8'b1000_0000, 8'h80, 1'b0, 0);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    idle_check("release4");
`else
    // Without the timeout a 20-cycle stall keeps the frame alive:
    // 1,1,1,0,0,0,0,1 from addr 0 -> 87.
    send_frame(3'd0, 8'b1000_0111, 8'h87, 1'b0, 20);
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    idle_check("release4");
`endif

    chk("sb_empty", exp_q.size() == 0 ? 8'd1 : 8'd0, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
